tag_bank_scheduler: RTL
=======================

# tag_bank_scheduler

Controller for a dual-port cache tag bank: port A for lookups, port B for writes. Clears every line after reset and on a flush request. Arbitrates two write requesters (invalidate, fill) onto port B. Handles same-line read/write collisions so a lookup never returns a stale or undefined tag. Sits between the cache's lookup/miss/coherence logic and the tag RAM.

## Interface
Parameters:
- WIDTH, 32: tag entry width in bits
- LINES, 512: tag lines; power of two, ≥2; AW = $clog2(LINES)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- lookup_valid  input  1  lookup request
- lookup_addr  input  AW  line to read
- lookup_ready  output  1  lookup accepted when valid&&ready
- lookup_resp_valid  output  1  response valid, one cycle after acceptance
- lookup_resp_data  output  WIDTH  tag read
- inval_valid / inval_ready  input / output  1  invalidate write handshake
- inval_addr, inval_data  input  AW, WIDTH  invalidate write line/value
- fill_valid / fill_ready  input / output  1  fill write handshake
- fill_addr, fill_data  input  AW, WIDTH  fill write line/value
- flush_req  input  1  single-cycle pulse: clear all lines
- flush_done  output  1  single-cycle pulse at end of any sweep
- busy  output  1  sweep in progress
- ram_en_a, ram_addr_a  output  1, AW  port A read strobe/address
- ram_data_out_a  input  WIDTH  port A registered read data (1-cycle latency)
- ram_en_b, ram_wen_b  output  1, 1  port B strobe/write enable (ram_wen_b==ram_en_b)
- ram_addr_b, ram_data_b  output  AW, WIDTH  port B write address/data

## Operation
- States: SWEEP, READY. Reset enters SWEEP with sweep_ctr=0.
- SWEEP: each cycle write 0 to line sweep_ctr via port B; sweep_ctr++. On sweep_ctr==LINES-1, write that line, pulse flush_done next cycle, enter READY. Counter is AW bits, wraps to 0. busy=1; lookup_ready, inval_ready, fill_ready all 0; port A idle.
- READY: flush_req → SWEEP with sweep_ctr=0 next cycle. Requests presented in the flush_req cycle are still serviced. flush_req during SWEEP is ignored; the current sweep's flush_done satisfies it.
- Write arbitration in READY: fixed priority inval > fill. inval_ready=1; fill_ready=!inval_valid. Winner drives port B in the handshake cycle. No write buffering.
- Lookup: lookup_ready=1 in READY unless stalled (see Configuration). Accepted lookup drives port A that cycle. No lookup → ram_en_a=0.
- Collision: accepted lookup and port-B write to the same line in the same cycle. RAM result is undefined; handled per Configuration. Same-line write in cycle N-1 then lookup in N needs no handling; the RAM returns the new value.
- Reset values: lookup_resp_valid=0, lookup_resp_data=0, flush_done=0, busy=1, all ready=0, ram_en_a=0, sweep_ctr=0. ram_en_b=1 from the first cycle after reset release.
- Reset asserted mid-sweep or mid-lookup: immediate return to reset values; in-flight response is dropped; sweep restarts at line 0.

## Timing
- Lookup accepted cycle N → lookup_resp_valid=1 in N+1; data = ram_data_out_a or forwarded value. Back-to-back lookups every cycle.
- Write handshake cycle N → RAM updated at end of N.
- Sweep length: LINES cycles. flush_done pulses in cycle LINES after sweep start (init: after reset release). First lookup_ready=1 in that same cycle.
- ready signals depend on state and valid inputs only; lookup_ready additionally on write addresses when the bypass macro is absent.

## Configuration
- TAG_BANK_SCHED_BYPASS_EN defined: collisions are forwarded. Register the write data and a hit flag in cycle N; in N+1, lookup_resp_data = that write data. lookup_ready stays 1.
- Undefined: lookup_ready=0 in any cycle where a port-B write is granted to lookup_addr; the lookup retries next cycle. Forwarding mux and registers are absent.

## Test plan
- Reset release, LINES=8 → busy=1 and ram_wen_b=1 for addresses 0..7 over 8 cycles, then flush_done pulse, busy=0, lookup_ready=1.
- fill addr 3 data 0xABCD, next cycle lookup addr 3 → resp_valid next cycle with 0xABCD.
- inval_valid and fill_valid same cycle (inval addr 2 data 0x1, fill addr 5 data 0x2) → inval written, fill_ready=0; fill written next cycle.
- Lookup addr 4 same cycle as fill addr 4 data 0x55 → with macro: resp 0x55 in N+1. Without macro: lookup_ready=0 in N, resp 0x55 in N+2.
- flush_req after writes; flush_req again mid-sweep → single 8-cycle sweep, one flush_done; all lookups then return 0.
- Reset asserted at sweep_ctr=5 → outputs at reset values immediately; after release, sweep restarts at address 0.

Source files
------------

// File: rtl/tag_bank_scheduler_if.sv
// Signal bundle between tag_bank_scheduler, its lookup/write/flush clients and the dual-port tag RAM.
// slave: the scheduler's view; master: the client/RAM side.
interface tag_bank_scheduler_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LINES = 512
);
    localparam int unsigned AW = $clog2(LINES);

    logic             lookup_valid;
    logic             lookup_ready;
    logic [AW-1:0]    lookup_addr;
    logic             lookup_resp_valid;
    logic [WIDTH-1:0] lookup_resp_data;

    logic             inval_valid;
    logic             inval_ready;
    logic [AW-1:0]    inval_addr;
    logic [WIDTH-1:0] inval_data;

    logic             fill_valid;
    logic             fill_ready;
    logic [AW-1:0]    fill_addr;
    logic [WIDTH-1:0] fill_data;

    logic             flush_req;
    logic             flush_done;
    logic             busy;

    logic             ram_en_a;
    logic [AW-1:0]    ram_addr_a;
    logic [WIDTH-1:0] ram_data_out_a;
    logic             ram_en_b;
    logic             ram_wen_b;
    logic [AW-1:0]    ram_addr_b;
    logic [WIDTH-1:0] ram_data_b;

    modport slave (
        input  lookup_valid, lookup_addr,
        input  inval_valid, inval_addr, inval_data,
        input  fill_valid, fill_addr, fill_data,
        input  flush_req, ram_data_out_a,
        output lookup_ready, lookup_resp_valid, lookup_resp_data,
        output inval_ready, fill_ready, flush_done, busy,
        output ram_en_a, ram_addr_a, ram_en_b, ram_wen_b, ram_addr_b, ram_data_b
    );

    modport master (
        output lookup_valid, lookup_addr,
        output inval_valid, inval_addr, inval_data,
        output fill_valid, fill_addr, fill_data,
        output flush_req, ram_data_out_a,
        input  lookup_ready, lookup_resp_valid, lookup_resp_data,
        input  inval_ready, fill_ready, flush_done, busy,
        input  ram_en_a, ram_addr_a, ram_en_b, ram_wen_b, ram_addr_b, ram_data_b
    );
endinterface

// File: rtl/tag_bank_scheduler.sv
// Tag bank controller: clear sweep, inval>fill write arbitration on port B, lookups on port A.
// Optional macro TAG_BANK_SCHED_BYPASS_EN forwards same-line write data instead of stalling the lookup.
module tag_bank_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LINES = 512
) (
    input logic                  clk,
    input logic                  rst,
    tag_bank_scheduler_if.slave  bus
);
    localparam int unsigned AW = $clog2(LINES);

    typedef enum logic {SWEEP, READY} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    sweep_ctr, sweep_ctr_nxt;
    logic             flush_done_q, flush_done_nxt;
    logic             resp_valid_q;
    logic             inval_ready, fill_ready, lookup_ready;
    logic             wr_grant, port_b_en, lookup_accept;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= SWEEP;
            sweep_ctr    <= '0;
            flush_done_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            sweep_ctr    <= sweep_ctr_nxt;
            flush_done_q <= flush_done_nxt;
            resp_valid_q <= lookup_accept;
        end
    end

    // Next state, sweep writes and write arbitration.
    always_comb begin
        state_nxt      = state;
        sweep_ctr_nxt  = sweep_ctr;
        flush_done_nxt = 1'b0;
        inval_ready    = 1'b0;
        fill_ready     = 1'b0;
        wr_grant       = 1'b0;
        port_b_en      = 1'b0;
        wr_addr        = sweep_ctr;
        wr_data        = '0;
        case (state)
            SWEEP: begin
                port_b_en     = 1'b1;
                sweep_ctr_nxt = sweep_ctr + AW'(1);
                if (sweep_ctr == AW'(LINES - 1)) begin
                    state_nxt      = READY;
                    flush_done_nxt = 1'b1;
                end
            end
            READY: begin
                inval_ready = 1'b1;
                fill_ready  = !bus.inval_valid;
                if (bus.inval_valid) begin
                    wr_grant = 1'b1;
                    wr_addr  = bus.inval_addr;
                    wr_data  = bus.inval_data;
                end else if (bus.fill_valid) begin
                    wr_grant = 1'b1;
                    wr_addr  = bus.fill_addr;
                    wr_data  = bus.fill_data;
                end
                port_b_en = wr_grant;
                if (bus.flush_req) begin
                    state_nxt     = SWEEP;
                    sweep_ctr_nxt = '0;
                end
            end
            default: state_nxt = SWEEP;
        endcase
    end

`ifdef TAG_BANK_SCHED_BYPASS_EN
    logic             hit_q;
    logic [WIDTH-1:0] fwd_q;

    assign lookup_ready = (state == READY);

    // Same-cycle same-line write: the RAM read is undefined, so remember the write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= 1'b0;
            fwd_q <= '0;
        end else begin
            hit_q <= lookup_accept && wr_grant && (wr_addr == bus.lookup_addr);
            fwd_q <= wr_data;
        end
    end

    assign bus.lookup_resp_data = !resp_valid_q ? '0 : (hit_q ? fwd_q : bus.ram_data_out_a);
`else
    // Stall a lookup that would read the line being written this cycle.
    assign lookup_ready = (state == READY) && !(wr_grant && (wr_addr == bus.lookup_addr));
    assign bus.lookup_resp_data = resp_valid_q ? bus.ram_data_out_a : '0;
`endif

    assign lookup_accept         = bus.lookup_valid && lookup_ready;
    assign bus.lookup_ready      = lookup_ready;
    assign bus.lookup_resp_valid = resp_valid_q;
    assign bus.inval_ready       = inval_ready;
    assign bus.fill_ready        = fill_ready;
    assign bus.flush_done        = flush_done_q;
    assign bus.busy              = (state == SWEEP);
    assign bus.ram_en_a          = lookup_accept;
    assign bus.ram_addr_a        = bus.lookup_addr;
    assign bus.ram_en_b          = port_b_en;
    assign bus.ram_wen_b         = port_b_en;
    assign bus.ram_addr_b        = wr_addr;
    assign bus.ram_data_b        = wr_data;
endmodule
